// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data memory.
package dmem_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } dmem_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned BYTE_W     = 8;

endpackage

// File: rtl/dmem_rd_pipe.sv
// Stallable read-latency pipeline: every stage carries valid, data and error,
// and all stages freeze together while the output is valid but not accepted.
module dmem_rd_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_err_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_err_o,
  output logic              stall_o
);

  localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic [LAT-1:0]    vld_q;
  logic [LAT-1:0]    err_q;
  logic [DATA_W-1:0] dat_q [LAT];

  assign stall_o = vld_q[LAT-1] & ~out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else if (!stall_o) begin
      vld_q[0] <= in_valid_i;
      err_q[0] <= in_err_i;
      dat_q[0] <= in_data_i;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[LAT-1];
  assign out_data_o  = dat_q[LAT-1];
  assign out_err_o   = err_q[LAT-1];

endmodule

// File: rtl/data_memory_hs.sv
// Single-port word memory with valid/ready request and response channels,
// byte-lane writes, out-of-range detection and optional zero-fill after reset.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned DEPTH          = 2048,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/BYTE_W-1:0] req_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     init_busy
);

  localparam int unsigned       NBYTES    = DATA_W / BYTE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic              fill_we;
  logic              pipe_stall;
  logic              accept;
  logic              addr_ok;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      fill_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  // Reset always parks in INIT; without zero-fill INIT just hands over to RUN.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_we     = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (!CLEAR_ON_RESET) begin
          state_d = ST_RUN;
        end else begin
          fill_we = rst_n;
          if (fill_addr_q == LAST_ADDR) begin
            state_d     = ST_RUN;
            fill_addr_d = '0;
          end else begin
            fill_addr_d = fill_addr_q + 1'b1;
          end
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign init_busy = CLEAR_ON_RESET && (state_q == ST_INIT);
  assign req_ready = (state_q == ST_RUN) && !pipe_stall;
  assign accept    = req_valid && req_ready;
  assign addr_ok   = 32'(req_addr) < DEPTH;

  // The array has no reset; only the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem_q[fill_addr_q] <= '0;
    end else if (accept && req_write && addr_ok) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (req_be[b]) begin
          mem_q[req_addr][b*BYTE_W +: BYTE_W] <= req_wdata[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr_ok) begin
      rd_data = mem_q[req_addr];
    end
  end

  dmem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (accept && !req_write),
    .in_data_i   (rd_data),
    .in_err_i    (!addr_ok),
    .out_ready_i (rsp_ready),
    .out_valid_o (rsp_valid),
    .out_data_o  (rsp_rdata),
    .out_err_o   (rsp_err),
    .stall_o     (pipe_stall)
  );

endmodule

// File: tb/tb_data_memory_hs.sv
// Self-checking bench for data_memory_hs: directed scenarios plus a random
// phase, scored against an array/queue reference model.
module tb_data_memory_hs;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned DEP = 12;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          init_busy;

  always #5 clk = ~clk;

  data_memory_hs #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .DEPTH          (DEP),
    .RD_LAT         (LAT),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] model [DEP];
  int            n_checks   = 0;
  int            n_fail     = 0;
  int            cyc        = 0;
  int            init_left  = 0;
  int            last_stall = -1;
  logic          held_v     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_init_busy", 32'(init_busy), 1);
  endtask

  // Called at a falling edge; returns at the next falling edge (one cycle).
  task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [1:0] be, input logic rr);
    logic exp_ready;
    exp_t e;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    rsp_ready = rr;
    #1;
    chk("init_busy", 32'(init_busy), 32'(init_left > 0));
    exp_ready = (init_left == 0) && !(rsp_valid && !rr);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (held_v) chk("stall_hold_valid", 32'(rsp_valid), 1);
    if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid), 0);
      end else begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(q[0].data));
        chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        if (rr) begin
          if (last_stall < q[0].acc) chk("latency", 32'(cyc - q[0].acc), LAT);
          void'(q.pop_front());
        end
      end
    end else if (q.size() > 0 && last_stall < q[0].acc && cyc >= q[0].acc + int'(LAT)) begin
      chk("rsp_missing", 32'(rsp_valid), 1);
    end
    held_v = rsp_valid && !rr;
    if (held_v) last_stall = cyc;
    if (v && exp_ready) begin
      if (w) begin
        if (a < DEP) begin
          if (be[0]) model[a][7:0]  = d[7:0];
          if (be[1]) model[a][15:8] = d[15:8];
        end
      end else begin
        e.data = '0;
        if (a < DEP) e.data = model[a];
        e.err = (a >= DEP);
        e.acc = cyc;
        q.push_back(e);
      end
    end
    @(posedge clk);
    if (init_left > 0) init_left--;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, rr);
  endtask

  task automatic release_reset();
    rst_n     = 1'b1;
    init_left = DEP;
    held_v    = 1'b0;
    q.delete();
    for (int i = 0; i < int'(DEP); i++) model[i] = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) idle(1, 1'b1);
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    reset_checks();

    // Reset in the middle of the zero-fill restarts it from scratch.
    @(negedge clk);
    release_reset();
    idle(5, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    release_reset();
    idle(DEP + 1, 1'b1);

    step(1'b1, 1'b0, 4'd5, '0, '0, 1'b1);
    drain();

    step(1'b1, 1'b1, 4'd3, 16'hABCD, 2'b11, 1'b1);
    step(1'b1, 1'b1, 4'd3, 16'h1234, 2'b01, 1'b1);
    step(1'b1, 1'b0, 4'd3, '0, '0, 1'b1);
    step(1'b1, 1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b1);
    step(1'b1, 1'b0, 4'd3, '0, '0, 1'b1);
    drain();

    step(1'b1, 1'b1, 4'd0, 16'h1111, 2'b11, 1'b1);
    step(1'b1, 1'b1, 4'd1, 16'h2222, 2'b11, 1'b1);
    step(1'b1, 1'b1, 4'd2, 16'h3333, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, AW'(i), '0, '0, 1'b1);
    drain();

    step(1'b1, 1'b1, 4'd13, 16'hDEAD, 2'b11, 1'b1);
    step(1'b1, 1'b0, 4'd13, '0, '0, 1'b1);
    for (int i = 0; i < int'(DEP); i++) step(1'b1, 1'b0, AW'(i), '0, '0, 1'b1);
    drain();

    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, AW'(i), '0, '0, !(i >= 4 && i < 8));
    drain();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           DW'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    drain();

    // Reset with one response stalled at the output and another in flight.
    step(1'b1, 1'b0, 4'd1, '0, '0, 1'b1);
    step(1'b1, 1'b0, 4'd2, '0, '0, 1'b1);
    idle(2, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    release_reset();
    idle(DEP + 8, 1'b1);
    step(1'b1, 1'b0, 4'd1, '0, '0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_hs.md
DATA_MEMORY_HS -- requirements
Module: data_memory_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 11, address width.
REQ-003 SHALL have parameter DEPTH, default 2048, number of words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-fill the array after reset.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-010 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, ADDR_W, word address.
REQ-012 SHALL have port req_wdata, input, DATA_W, write data.
REQ-013 SHALL have port req_be, input, DATA_W/8, byte-lane write enables.
REQ-014 SHALL have port rsp_valid, output, 1, read response present.
REQ-015 SHALL have port rsp_ready, input, 1, response consumed when high with rsp_valid.
REQ-016 SHALL have port rsp_rdata, output, DATA_W, read data.
REQ-017 SHALL have port rsp_err, output, 1, the response address was out of range.
REQ-018 SHALL have port init_busy, output, 1, zero-fill in progress.

Function
REQ-019 SHALL run an FSM with states INIT and RUN; on reset release it enters INIT if CLEAR_ON_RESET=1, otherwise RUN.
REQ-020 INIT SHALL write zero to one address per cycle from 0 to DEPTH-1, then move to RUN; it takes exactly DEPTH cycles.
REQ-021 In INIT, req_ready SHALL be 0 and init_busy SHALL be 1; in RUN, init_busy SHALL be 0.
REQ-022 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; at most one is accepted per cycle.
REQ-023 An accepted write SHALL update only the byte lanes whose req_be bit is 1, on the acceptance edge.
REQ-024 A write SHALL produce no response.
REQ-025 An accepted read SHALL produce exactly one response, with rsp_valid high RD_LAT cycles after acceptance when there is no backpressure.
REQ-026 Read data SHALL reflect every write accepted before the read's acceptance cycle.
REQ-027 Responses SHALL be returned in acceptance order.
REQ-028 When rsp_valid=1 and rsp_ready=0, the read pipeline SHALL hold every stage and req_ready SHALL be 0.
REQ-029 rsp_rdata and rsp_err SHALL remain stable while the response is stalled.
REQ-030 When not in INIT and not stalled, req_ready SHALL be 1; back-to-back reads SHALL sustain one response per cycle.
REQ-031 A write with req_addr >= DEPTH SHALL be dropped without error signalling.
REQ-032 A read with req_addr >= DEPTH SHALL return rsp_rdata=0 with rsp_err=1.
REQ-033 A write with req_be all zero SHALL be accepted and change nothing.

Reset
REQ-034 While rst_n=0: rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0, all pipeline stages invalid, FSM=INIT.
REQ-035 init_busy SHALL equal CLEAR_ON_RESET while rst_n=0.
REQ-036 Reset asserted mid-INIT or with reads in flight SHALL discard all in-flight reads.
REQ-037 Reset asserted mid-INIT SHALL restart the zero-fill from address 0 on release.
REQ-038 Array contents SHALL NOT be cleared by reset itself; only INIT clears them.

Structure
REQ-039 SHALL place the FSM state type, RD_LAT limits (1..4) and the byte-lane width constant (8) in shared package dmem_pkg.
REQ-040 SHALL implement the stallable latency pipeline (valid, data, err per stage) as sub-module dmem_rd_pipe, parameterised by DATA_W and RD_LAT.

Verification
REQ-041 Zero-fill: DEPTH=16, CLEAR_ON_RESET=1, release reset -> init_busy high exactly 16 cycles; then read addr 5 -> rdata 0x0000, err 0.
REQ-042 Byte enables: write 0xABCD to addr 3 with be=11, then 0x1234 with be=01; read addr 3 -> 0xAB34.
REQ-043 Latency and throughput: RD_LAT=3, reads to addr 0,1,2 on consecutive cycles -> rsp_valid on cycles +3,+4,+5 with data in order.
REQ-044 Backpressure: hold rsp_ready=0 for 4 cycles during a read burst -> req_ready=0, rsp_rdata stable, no response lost or duplicated.
REQ-045 Range: DEPTH=12, ADDR_W=4, write addr 13, then read addr 13 -> rdata 0, err 1; addr 0..11 unchanged.
REQ-046 Reset mid-flight: assert rst_n=0 with 2 reads pending -> rsp_valid drops at once, no stale response after release.
